ece571_alu_mc: RTL and testbench



---
 rtl/ece571_cpu_pkg.sv | 41 ++++
 rtl/ece571_alu_mc_mul_iter.sv | 71 +++++++
 rtl/ece571_alu_mc.sv | 188 ++++++++++++++++++
 tb/tb_ece571_alu_mc.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ece571_cpu_pkg.sv
// -----------------------------------------------------------------------------
// ece571_cpu_pkg
// Shared CPU types: the ALU opcode set (original encodings 0-4 plus the
// shift/multiply extensions 5-8), the ALU condition-flag bundle and the state
// type of the multi-cycle ALU control FSM.
// -----------------------------------------------------------------------------
package ece571_cpu_pkg;

    // Encodings 0..4 are the legacy combinational-ALU ops and must not move.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8
    } opcode_t;

    // Condition flags: zero, negative, carry/borrow, signed overflow.
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } alu_state_t;

    // True for the only opcode that takes the multi-cycle path.
    function automatic logic op_is_mul(input opcode_t op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/ece571_alu_mc_mul_iter.sv
// -----------------------------------------------------------------------------
// ece571_mul_iter
// Iterative shift-add unsigned multiplier. Operands are captured on the cycle
// start is high; one multiplier bit is consumed per clock for exactly N clocks,
// after which done pulses for one cycle with the full 2N-bit product.
// Ports:
//   clk, reset   shared clock / asynchronous active-high reset
//   start        capture a and b and begin a multiply
//   a, b         N-bit unsigned operands
//   done         one-cycle pulse, product valid while high
//   product      2N-bit unsigned product
// -----------------------------------------------------------------------------
module ece571_mul_iter #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(N);

    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_prod;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;

    // Shift-add iteration: add the shifted multiplicand when the current
    // multiplier LSB is set, then advance both operands by one bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= {(2*N){1'b0}};
            r_mplier <= {N{1'b0}};
            r_prod   <= {(2*N){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{N{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= {(2*N){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == C_LAST) begin
                // The done cycle: product has been presented, go quiet.
                r_busy <= 1'b0;
            end else begin
                if (r_mplier[0]) begin
                    r_prod <= r_prod + r_mcand;
                end else begin
                    r_prod <= r_prod;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            r_busy <= 1'b0;
        end
    end

    assign done    = r_busy && (r_cnt == C_LAST);
    assign product = r_prod;

endmodule

// File: rtl/ece571_alu_mc.sv
// -----------------------------------------------------------------------------
// ece571_alu_mc
// Multi-cycle handshaked ALU stage. Single-cycle ops (add/sub/logic/shifts and
// unsupported opcodes) complete with latency 1; MUL runs on the iterative
// multiplier for N cycles. Results, flags and the illegal indication are held
// in an output register until the consumer takes them.
// Ports:
//   clk, reset            clock / asynchronous active-high reset
//   in_valid, in_ready    input handshake (transfer when both high)
//   opcode, a, b          operation and operands (captured at transfer)
//   out_valid, out_ready  output handshake (transfer when both high)
//   result, flags         registered result and {z, n, c, v}
//   illegal               registered unsupported-opcode indication
// -----------------------------------------------------------------------------
module ece571_alu_mc
    import ece571_cpu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  opcode_t      opcode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output alu_flags_t   flags,
    output logic         illegal
);

    localparam int SW = $clog2(N);

    alu_state_t     r_state;
    alu_state_t     w_state_nxt;
    logic           w_accept;
    logic           w_mul_start;
    logic           w_load_single;
    logic           w_load_mul;
    logic           w_mul_done;
    logic [2*N-1:0] w_product;
    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [SW-1:0]  w_shamt;
    logic [N-1:0]   w_res;
    alu_flags_t     w_flags;
    logic           w_illegal;
    alu_flags_t     w_mflags;

    logic [N-1:0]   r_result;
    alu_flags_t     r_flags;
    logic           r_illegal;
    logic           r_out_valid;

    // in_ready is combinational from out_ready so HOLD can drain and accept
    // on the same edge.
    assign in_ready      = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
    assign w_accept      = in_valid && in_ready;
    assign w_mul_start   = w_accept && op_is_mul(opcode);
    assign w_load_single = w_accept && !op_is_mul(opcode);
    assign w_load_mul    = (r_state == MUL) && w_mul_done;

    ece571_mul_iter #(.N(N)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Single-cycle datapath and flags, evaluated on the operands being accepted.
    always_comb begin
        w_sum     = {1'b0, a} + {1'b0, b};
        w_diff    = {1'b0, a} - {1'b0, b};
        w_shamt   = b[SW-1:0];
        w_res     = {N{1'b0}};
        w_flags   = 4'b0000;
        w_illegal = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_res     = w_sum[N-1:0];
                w_flags.c = w_sum[N];
                // Overflow: like-signed operands, result sign differs.
                w_flags.v = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_res     = w_diff[N-1:0];
                // Bit N of the widened difference is the borrow (a < b).
                w_flags.c = w_diff[N];
                w_flags.v = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SLL: w_res = a << w_shamt;
            OP_SRL: w_res = a >> w_shamt;
            OP_SRA: w_res = $unsigned($signed(a) >>> w_shamt);
            OP_MUL: w_res = {N{1'b0}};
            default: w_illegal = 1'b1;
        endcase
        w_flags.z = (w_res == {N{1'b0}});
        w_flags.n = w_res[N-1];
    end

    // Multiply flags: carry reports a non-zero upper half of the product.
    always_comb begin
        w_mflags   = 4'b0000;
        w_mflags.z = (w_product[N-1:0] == {N{1'b0}});
        w_mflags.n = w_product[N-1];
        w_mflags.c = |w_product[2*N-1:N];
    end

    // Control FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = op_is_mul(opcode) ? MUL : HOLD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = MUL;
                end
            end
            HOLD: begin
                if (!out_ready) begin
                    w_state_nxt = HOLD;
                end else if (w_accept) begin
                    w_state_nxt = op_is_mul(opcode) ? MUL : HOLD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output register: loads on a single-cycle accept or on multiplier done,
    // otherwise holds (covers back-pressure).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result    <= {N{1'b0}};
            r_flags     <= 4'b0000;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == HOLD);
            if (w_load_single) begin
                r_result  <= w_res;
                r_flags   <= w_flags;
                r_illegal <= w_illegal;
            end else if (w_load_mul) begin
                r_result  <= w_product[N-1:0];
                r_flags   <= w_mflags;
                r_illegal <= 1'b0;
            end else begin
                r_result  <= r_result;
                r_flags   <= r_flags;
                r_illegal <= r_illegal;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_ece571_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_ece571_alu_mc
// Scoreboard bench: the driver pushes the expected response when an op is
// accepted; an independent monitor pops and compares on every output transfer
// and checks that a stalled output stays stable.
// -----------------------------------------------------------------------------
module tb_ece571_alu_mc;
    import ece571_cpu_pkg::*;

    localparam int N      = 32;
    localparam int BUDGET = 200;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    opcode_t      opcode = OP_ADD;
    logic [N-1:0] a = 32'd0;
    logic [N-1:0] b = 32'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] result;
    alu_flags_t   flags;
    logic         illegal;

    typedef struct {
        logic [N-1:0] res;
        alu_flags_t   fl;
        logic         ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   rnd_rdy = 1'b0;

    ece571_alu_mc #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] r, input logic z, input logic n,
                                input logic c, input logic v, input logic ill);
        exp_t e;
        e.res = r; e.fl.z = z; e.fl.n = n; e.fl.c = c; e.fl.v = v; e.ill = ill;
        return e;
    endfunction

    // Reference model: plain 64-bit arithmetic and signed range tests.
    function automatic exp_t model(input opcode_t op, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t   e;
        longint sx, sy, s;
        logic [63:0] w;
        int     sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y % 32);
        e.res = 32'd0; e.fl = 4'b0000; e.ill = 1'b0;
        case (op)
            OP_ADD: begin
                w = 64'(x) + 64'(y);
                e.res = w[31:0];
                e.fl.c = (w >= 64'h1_0000_0000);
                s = sx + sy;
                e.fl.v = (s > SMAX) || (s < SMIN);
            end
            OP_SUB: begin
                e.res = x - y;
                e.fl.c = (x < y);
                s = sx - sy;
                e.fl.v = (s > SMAX) || (s < SMIN);
            end
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_XOR: e.res = x ^ y;
            OP_SLL: e.res = x << sh;
            OP_SRL: e.res = x >> sh;
            OP_SRA: begin
                s = sx >>> sh;
                e.res = s[31:0];
            end
            OP_MUL: begin
                w = 64'(x) * 64'(y);
                e.res = w[31:0];
                e.fl.c = ((w >> 32) != 64'd0);
            end
            default: begin
                e.ill = 1'b1;
                e.res = 32'd0;
            end
        endcase
        e.fl.z = (e.res == 32'd0);
        e.fl.n = e.res[31];
        return e;
    endfunction

    // Present one op, wait (bounded) for acceptance, push its expectation.
    // Inputs are scrambled right after acceptance to prove capture.
    task automatic issue(input opcode_t op, input logic [N-1:0] x, input logic [N-1:0] y,
                         input exp_t e, input bit lat);
        int  w;
        bit  lowok;
        w = 0;
        in_valid = 1'b1; opcode = op; a = x; b = y;
        @(negedge clk);
        while (!in_ready) begin
            w++;
            if (w >= BUDGET) begin
                n_tests++; n_fail++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", w);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        opcode = opcode_t'(4'($urandom_range(0, 15)));
        if (lat) begin
            if (op == OP_MUL) begin
                lowok = 1'b1;
                for (int i = 0; i < N; i++) begin
                    @(negedge clk);
                    if (in_ready !== 1'b0) lowok = 1'b0;
                end
                check("mul_in_ready_low", 64'(lowok), 64'd1);
                @(posedge clk); #1;
                check("mul_not_early", 64'(out_valid), 64'd0);
                @(posedge clk); #1;
                check("mul_latency", 64'(out_valid), 64'd1);
            end else begin
                check("latency1", 64'(out_valid), 64'd1);
            end
        end
    endtask

    // Monitor: compare every output transfer against the scoreboard head and
    // check that a stalled output does not move.
    initial begin : monitor
        exp_t         e;
        logic [N-1:0] p_res;
        alu_flags_t   p_fl;
        logic         p_ill;
        bit           held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
            end else if (out_valid) begin
                if (held) begin
                    check("hold_result", 64'(result), 64'(p_res));
                    check("hold_flags", 64'(flags), 64'(p_fl));
                    check("hold_illegal", 64'(illegal), 64'(p_ill));
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (sb_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_output: result %h with empty scoreboard", result);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", 64'(result), 64'(e.res));
                        check("flags", 64'(flags), 64'(e.fl));
                        check("illegal", 64'(illegal), 64'(e.ill));
                    end
                end else begin
                    held = 1'b1; p_res = result; p_fl = flags; p_ill = illegal;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Random back-pressure, enabled only during the random phase.
    initial begin : rdy_gen
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [N-1:0] x, y;
        opcode_t      op;
        int           c0, w;
        bit           lowok;
        logic [N-1:0] edge_v [6];
        edge_v[0] = 32'h0000_0000; edge_v[1] = 32'hFFFF_FFFF; edge_v[2] = 32'h8000_0000;
        edge_v[3] = 32'h7FFF_FFFF; edge_v[4] = 32'h0000_0001; edge_v[5] = 32'h0001_0000;

        // Reset state.
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic corners.
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
        issue(OP_SUB, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
        issue(OP_SUB, 32'd9, 32'd9, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(OP_SRA, 32'h8000_0010, 32'd4, mk(32'hF800_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(OP_SLL, 32'd3, 32'h21, mk(32'h0000_0006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
        issue(OP_MUL, 32'd6, 32'd7, mk(32'd42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: stall the output, then drain and accept together.
        out_ready = 1'b0;
        issue(OP_ADD, 32'd100, 32'd23, mk(32'd123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        x = 32'h1234_5678; y = 32'h0F0F_0F0F;
        in_valid = 1'b1; opcode = OP_ADD; a = x; b = y;
        lowok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0) lowok = 1'b0;
        end
        check("bp_in_ready_low", 64'(lowok), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        c0 = cyc;
        issue(OP_ADD, x, y, model(OP_ADD, x, y), 1'b1);
        for (int i = 0; i < 4; i++) begin
            x = $urandom; y = $urandom;
            issue(OP_ADD, x, y, model(OP_ADD, x, y), 1'b1);
        end
        check("throughput_cycles", 64'(cyc - c0), 64'd5);

        // Reset in the middle of a multiply.
        issue(OP_MUL, 32'hDEAD_BEEF, 32'h1357_9BDF, model(OP_MUL, 32'hDEAD_BEEF, 32'h1357_9BDF), 1'b0);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_result", 64'(result), 64'd0);
        sb_q.delete();
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(OP_ADD, 32'd2, 32'd3, mk(32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(opcode_t'(4'hF), 32'hAAAA_5555, 32'h1, mk(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, model(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1);

        // Randomized ops with random back-pressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = opcode_t'(4'($urandom_range(0, 15)));
            x = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : 32'($urandom);
            y = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : 32'($urandom);
            issue(op, x, y, model(op, x, y), 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Drain with a bounded wait.
        w = 0;
        while ((sb_q.size() != 0 || out_valid) && w < BUDGET) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
